// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
//
// Sequencer for a single mux-scan chain whose flops sample on the falling edge
// of CLK. One run loads a parallel pattern into the chain, lets the chain take
// one functional capture, then unloads it and presents the captured chain
// state as a parallel word. The controller itself works on the rising edge,
// so SE/SI are stable for half a period before the chain samples them.
//
// Optional feature: define SCAN_CMP_EN to add an expected/mask comparison.
// The compare result is reported on MISMATCH together with DONE.
//
// Parameters
//   CHAIN_LEN   number of flops in the chain (2..256)
//
// Ports
//   CLK         clock (controller posedge, chain negedge)
//   RST         asynchronous active-high reset
//   START       one-cycle request to run a sequence, ignored while BUSY
//   ABORT       synchronous abort, only acted on while BUSY
//   PATTERN_IN  pattern to shift in, sampled on the START cycle
//   EXPECT_IN   (SCAN_CMP_EN) expected capture, sampled on the START cycle
//   MASK_IN     (SCAN_CMP_EN) don't-care mask (1 = ignore), sampled on START
//   SO          scan-out from the last chain flop
//   SE          scan enable to all chain flops
//   SI          scan-in to the first chain flop
//   BUSY        high from the cycle after START up to and including DONE
//   DONE        one-cycle pulse, RESULT valid
//   RESULT      captured chain contents, RESULT[k] is the k-th bit unloaded
//   MISMATCH    (SCAN_CMP_EN) masked compare of RESULT against EXPECT_IN
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PATTERN_IN,
`ifdef SCAN_CMP_EN
  input  logic [CHAIN_LEN-1:0] EXPECT_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  output logic                 MISMATCH,
`endif
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [CHAIN_LEN-1:0] pat_r;
  logic [CHAIN_LEN-1:0] pat_nxt_s;
  logic [CHAIN_LEN-1:0] cap_r;
  logic [CHAIN_LEN-1:0] cap_nxt_s;
  logic [CHAIN_LEN-1:0] result_r;
  logic                 se_r;
  logic                 si_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 se_nxt_s;
  logic                 si_nxt_s;
  logic                 busy_nxt_s;
  logic                 done_nxt_s;
  logic                 load_res_s;
  logic                 start_acc_s;

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_r;
  logic [CHAIN_LEN-1:0] mask_r;
  logic                 mismatch_r;

  // Any unmasked bit that differs from the expectation flags a miscompare.
  function automatic logic masked_miscompare(
    input logic [CHAIN_LEN-1:0] actual,
    input logic [CHAIN_LEN-1:0] expected,
    input logic [CHAIN_LEN-1:0] dont_care
  );
    return |((actual ^ expected) & ~dont_care);
  endfunction
`endif

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, counter, shadow registers and next values of the outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pat_nxt_s   = pat_r;
    cap_nxt_s   = cap_r;
    si_nxt_s    = 1'b0;
    load_res_s  = 1'b0;
    start_acc_s = 1'b0;

    if (ABORT && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            // Bit 0 goes out in the first shift cycle; the rest waits in pat_r.
            start_acc_s = 1'b1;
            state_nxt_s = ST_SHIFT_IN;
            cnt_nxt_s   = CNT_ZERO;
            si_nxt_s    = PATTERN_IN[0];
            pat_nxt_s   = {1'b0, PATTERN_IN[CHAIN_LEN-1:1]};
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_SHIFT_IN: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_CAPTURE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            si_nxt_s    = pat_r[0];
            pat_nxt_s   = {1'b0, pat_r[CHAIN_LEN-1:1]};
          end
        end
        ST_CAPTURE: begin
          // SO already shows the captured last flop at the edge ending CAPTURE.
          state_nxt_s = ST_SHIFT_OUT;
          cnt_nxt_s   = CNT_ZERO;
          cap_nxt_s   = {SO, cap_r[CHAIN_LEN-1:1]};
        end
        ST_SHIFT_OUT: begin
          if (cnt_r == CNT_LAST) begin
            // All CHAIN_LEN samples are in cap_r; SO here is don't-care.
            state_nxt_s = ST_FINISH;
            cnt_nxt_s   = CNT_ZERO;
            load_res_s  = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            cap_nxt_s   = {SO, cap_r[CHAIN_LEN-1:1]};
          end
        end
        ST_FINISH: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end

    // Outputs are registered, so they follow the state being entered.
    se_nxt_s   = (state_nxt_s == ST_SHIFT_IN) || (state_nxt_s == ST_SHIFT_OUT);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_FINISH);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r      <= CNT_ZERO;
      pat_r      <= {CHAIN_LEN{1'b0}};
      cap_r      <= {CHAIN_LEN{1'b0}};
      result_r   <= {CHAIN_LEN{1'b0}};
      se_r       <= 1'b0;
      si_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef SCAN_CMP_EN
      exp_r      <= {CHAIN_LEN{1'b0}};
      mask_r     <= {CHAIN_LEN{1'b0}};
      mismatch_r <= 1'b0;
`endif
    end else begin
      cnt_r  <= cnt_nxt_s;
      pat_r  <= pat_nxt_s;
      cap_r  <= cap_nxt_s;
      se_r   <= se_nxt_s;
      si_r   <= si_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (load_res_s) begin
        result_r <= cap_r;
      end
`ifdef SCAN_CMP_EN
      if (start_acc_s) begin
        exp_r  <= EXPECT_IN;
        mask_r <= MASK_IN;
      end
      if (load_res_s) begin
        mismatch_r <= masked_miscompare(cap_r, exp_r, mask_r);
      end
`endif
    end
  end

  assign SE     = se_r;
  assign SI     = si_r;
  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;
`ifdef SCAN_CMP_EN
  assign MISMATCH = mismatch_r;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
//
// Drives scan_chain_ctrl (CHAIN_LEN=4) against a behavioural negedge scan
// chain. By default the chain's functional D is ~Q; chain_mode=1 ties D to a
// constant. Expected results come from a reference model that reasons about
// where each pattern bit lands in the chain and in which order bits come out.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         ABORT;
  logic [N-1:0] PATTERN_IN;
  logic [N-1:0] EXPECT_IN;
  logic [N-1:0] MASK_IN;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] RESULT;
`ifdef SCAN_CMP_EN
  logic         MISMATCH;
`endif

  int checks   = 0;
  int failures = 0;

  // chain model state
  logic [N-1:0] q = '0;
  bit           chain_mode = 1'b0;
  logic [N-1:0] d_tie = '0;

  // reference-model view of the sticky outputs
  logic [N-1:0] model_res = '0;
  logic         model_mis = 1'b0;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .PATTERN_IN (PATTERN_IN),
`ifdef SCAN_CMP_EN
    .EXPECT_IN  (EXPECT_IN),
    .MASK_IN    (MASK_IN),
    .MISMATCH   (MISMATCH),
`endif
    .SO         (SO),
    .SE         (SE),
    .SI         (SI),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT)
  );

  always #5 CLK = ~CLK;

  // Scan chain: q[0] is fed by SI, q[N-1] drives SO.
  always @(negedge CLK) begin
    if (SE) q <= {q[N-2:0], SI};
    else if (chain_mode) q <= d_tie;
    else q <= ~q;
  end
  assign SO = q[N-1];

  // Pattern bit i is shifted in i-th and ends i flops away from SO; the
  // k-th bit unloaded is the one k flops away from SO.
  function automatic logic [N-1:0] model_result(input logic [N-1:0] p);
    logic [N-1:0] loaded;
    logic [N-1:0] capt;
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) loaded[N-1-i] = p[i];
    capt = chain_mode ? d_tie : ~loaded;
    for (int k = 0; k < N; k++) r[k] = capt[N-1-k];
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_mis(input string tag);
`ifdef SCAN_CMP_EN
    check(tag, MISMATCH, model_mis);
`endif
  endtask

  // One full sequence. abort_k >= 0 aborts in SHIFT_OUT cycle abort_k.
  task automatic run_seq(input logic [N-1:0] p, input logic [N-1:0] ex,
                         input logic [N-1:0] mk, input int abort_k,
                         input bit poke, input bit with_abort);
    logic [N-1:0] exp_res;
    exp_res    = model_result(p);
    PATTERN_IN = p;
    EXPECT_IN  = ex;
    MASK_IN    = mk;
    START      = 1'b1;
    ABORT      = with_abort;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("busy_shift_in", BUSY, 1'b1);
      check("se_shift_in", SE, 1'b1);
      check("si_shift_in", SI, p[i]);
      check("done_shift_in", DONE, 1'b0);
      if (poke && i == 1) begin
        START = 1'b1;
        PATTERN_IN = ~p;
      end else begin
        START = 1'b0;
      end
      tick();
    end
    START = 1'b0;
    check("se_capture", SE, 1'b0);
    check("si_capture", SI, 1'b0);
    check("busy_capture", BUSY, 1'b1);
    tick();
    for (int k = 0; k < N; k++) begin
      check("se_shift_out", SE, 1'b1);
      check("si_shift_out", SI, 1'b0);
      check("done_shift_out", DONE, 1'b0);
      if (k == abort_k) ABORT = 1'b1;
      tick();
      if (k == abort_k) begin
        ABORT = 1'b0;
        check("busy_abort", BUSY, 1'b0);
        check("se_abort", SE, 1'b0);
        check("si_abort", SI, 1'b0);
        for (int j = 0; j < 3; j++) begin
          check("done_abort", DONE, 1'b0);
          check("result_abort", RESULT, model_res);
          check_mis("mismatch_abort");
          tick();
        end
        return;
      end
    end
    model_res = exp_res;
    model_mis = |((exp_res ^ ex) & ~mk);
    check("done_finish", DONE, 1'b1);
    check("busy_finish", BUSY, 1'b1);
    check("se_finish", SE, 1'b0);
    check("result", RESULT, model_res);
    check_mis("mismatch");
    tick();
    check("done_idle", DONE, 1'b0);
    check("busy_idle", BUSY, 1'b0);
    check("result_hold", RESULT, model_res);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    PATTERN_IN = '0;
    EXPECT_IN = '0;
    MASK_IN = '0;
    tick();
    tick();
    check("rst_se", SE, 1'b0);
    check("rst_si", SI, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_result", RESULT, '0);
    check_mis("rst_mismatch");
    RST = 1'b0;
    tick();

    // basic run: SI 1,1,0,1 and RESULT 0100
    run_seq(4'b1011, 4'b0100, 4'b0000, -1, 1'b0, 1'b0);
    check("basic_result", RESULT, 4'b0100);

    // asynchronous reset in SHIFT_IN cycle 2
    PATTERN_IN = 4'b0110;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    #2 RST = 1'b1;
    #1;
    check("arst_se", SE, 1'b0);
    check("arst_busy", BUSY, 1'b0);
    check("arst_result", RESULT, '0);
    check("arst_si", SI, 1'b0);
    check("arst_done", DONE, 1'b0);
    check_mis("arst_mismatch");
    tick();
    RST = 1'b0;
    model_res = '0;
    model_mis = 1'b0;
    tick();
    check("post_rst_busy", BUSY, 1'b0);

    // normal run after reset, then back-to-back with a START poke while busy
    run_seq(4'b1011, 4'b0100, 4'b0000, -1, 1'b0, 1'b0);
    run_seq(4'b0000, 4'b0110, 4'b0000, -1, 1'b1, 1'b0);
    check("b2b_result", RESULT, 4'b1111);
    tick();
    check("no_queued_start", BUSY, 1'b0);

    // compare cases, abort in SHIFT_OUT cycle 1 while MISMATCH is set
    run_seq(4'b1011, 4'b0110, 4'b0000, -1, 1'b0, 1'b0);
    run_seq(4'b0011, 4'b0000, 4'b0000, 1, 1'b0, 1'b0);
    check("abort_keeps_result", RESULT, 4'b0100);
    run_seq(4'b1011, 4'b0110, 4'b0010, -1, 1'b0, 1'b0);

    // START together with ABORT in IDLE: START wins
    run_seq(4'b1100, 4'b0011, 4'b0000, -1, 1'b0, 1'b1);

    // capture of a tied D value
    chain_mode = 1'b1;
    d_tie = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      run_seq(4'($urandom), 4'b1001, 4'b0000, -1, 1'b0, 1'b0);
      check("tie_result", RESULT, 4'b1001);
    end
    for (int t = 0; t < 4; t++) begin
      d_tie = 4'($urandom);
      run_seq(4'($urandom), 4'($urandom), 4'($urandom), -1, 1'b0, 1'b0);
    end

    // randomized runs with the inverting chain
    chain_mode = 1'b0;
    for (int t = 0; t < 16; t++) begin
      run_seq(4'($urandom), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1,
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer that drives one mux-scan chain of negedge-clocked scan flops. It generates SE and SI, shifts a parallel pattern into the chain, issues one functional capture cycle, then shifts the chain out and returns the captured state as a parallel word. It sits between the test/debug register interface and the chain's SE/SI/SO pins. It shares the chain's clock and changes its outputs on the opposite edge from the chain flops.

## Interface

Parameters:
- CHAIN_LEN, 16, number of flops in the chain; legal range 2..256.
- CNT_W, $clog2(CHAIN_LEN), width of the bit counter; derived, never overridden.

Ports:
- CLK  in  1  clock. Controller is posedge; the chain flops sample on negedge of the same CLK.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to run a load/capture/unload sequence; ignored while BUSY=1.
- ABORT  in  1  synchronous abort; valid only while BUSY=1.
- PATTERN_IN  in  CHAIN_LEN  pattern to shift in; sampled on the START cycle.
- SO  in  1  scan-out from the last flop of the chain.
- SE  out  1  scan enable to all chain flops.
- SI  out  1  scan-in to the first flop of the chain.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle pulse when RESULT is valid.
- RESULT  out  CHAIN_LEN  captured chain contents.

## Operation

- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
- IDLE: SE=0, SI=0, BUSY=0. When START=1, latch PATTERN_IN into the shadow register, clear the counter, and go to SHIFT_IN.
- SHIFT_IN: lasts CHAIN_LEN cycles. SE=1. In cycle i, SI=pattern[i], so bit 0 is shifted first and ends in the flop nearest SO. When counter=CHAIN_LEN-1, clear the counter and go to CAPTURE.
- CAPTURE: lasts one cycle. SE=0 and SI=0, so the chain loads functional D on that cycle's falling edge. Then go to SHIFT_OUT.
- SHIFT_OUT: lasts CHAIN_LEN cycles. SE=1, SI=0.
  - RESULT[k] = SO sampled at the rising edge that begins SHIFT_OUT cycle k, which is before that cycle's falling shift.
  - Samples are therefore taken at the rising edges ending CAPTURE and SHIFT_OUT cycles 0..CHAIN_LEN-2.
  - Assemble the samples in a shadow register. Copy it to RESULT on entry to FINISH.
- FINISH: lasts one cycle. DONE=1, SE=0. Then go to IDLE.
- ABORT while BUSY: go to IDLE on the next edge with SE=0 and SI=0. No DONE pulse. RESULT keeps its previous value.
- START while BUSY: ignored, no queuing. START and ABORT together in IDLE: START wins, because ABORT is only valid while BUSY.
- Counter wraps only through an explicit clear at each state exit. It never exceeds CHAIN_LEN-1.

## Timing

- Reset values: SE=0, SI=0, BUSY=0, DONE=0, RESULT=0, state=IDLE, counter=0.
- RST asserted mid-sequence forces the reset values immediately and asynchronously. The chain contents are left undefined.
- All outputs are registered on posedge CLK. The chain flops sample SE/SI half a cycle later on negedge.
- START sampled at edge t0:
  - SHIFT_IN occupies cycles t0+1..t0+N, where N=CHAIN_LEN.
  - CAPTURE is cycle t0+N+1.
  - SHIFT_OUT occupies cycles t0+N+2..t0+2N+1.
  - DONE is high in cycle t0+2N+2.
  - BUSY is high in cycles t0+1..t0+2N+2.
- Total latency from START to DONE is 2N+2 cycles. The next START is accepted in cycle t0+2N+3.
- SO must be stable at posedge, i.e. the chain's clock-to-Q must be less than half a period.

## Configuration

- SCAN_CMP_EN defined:
  - Adds input EXPECT_IN [CHAIN_LEN] and input MASK_IN [CHAIN_LEN], both latched on START.
  - Adds output MISMATCH [1], reset value 0.
  - MISMATCH is valid with DONE and equals |((RESULT ^ EXPECT) & ~MASK), where a MASK bit of 1 means don't-care.
  - MISMATCH holds until the next DONE or reset.
  - ABORT leaves MISMATCH unchanged.
- SCAN_CMP_EN undefined: these ports and their logic do not exist.

## Test plan

The bench models the chain as CHAIN_LEN negedge scan flops with D=~Q, unless a scenario states otherwise.

- Reset: assert RST mid-SHIFT_IN -> SE=0, BUSY=0, RESULT=0 immediately; after release, START runs normally.
- Basic run (CHAIN_LEN=4): PATTERN_IN=4'b1011, then START -> SI sequence 1,1,0,1. DONE arrives 10 cycles after START with RESULT=4'b0100.
- Back-to-back: START again in the cycle after DONE with PATTERN_IN=4'b0000 -> RESULT=4'b1111. A START pulsed while BUSY changes nothing.
- ABORT in SHIFT_OUT cycle 1 -> IDLE next cycle, no DONE pulse, RESULT still holds the previous value, SE=0.
- Capture check (chain D tied to 4'b1001 via the model) -> any pattern yields RESULT=4'b1001.
- With SCAN_CMP_EN, CHAIN_LEN=4:
  - EXPECT=4'b0100, MASK=0 -> MISMATCH=0.
  - EXPECT=4'b0110, MASK=0 -> MISMATCH=1.
  - EXPECT=4'b0110, MASK=4'b0010 -> MISMATCH=0.
